// File: rtl/load_store_unit.sv
// MEM-stage load/store controller for a word-only data memory: extracts sub-word loads,
// writes SW directly and turns SB/SH into a two-cycle read-modify-write.
module load_store_unit #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        access_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

   localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        half_q, half_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] old_q, old_d;
   logic [31:0] load_data_q, load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        access_err_q, access_err_d;

   logic        legal_f3, misaligned, out_of_range, req_err;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_ext, merged_word;

   always_comb begin
      if (req_we) legal_f3 = req_funct3 inside {3'b000, 3'b001, 3'b010};
      else        legal_f3 = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      out_of_range = {2'b00, req_addr[31:2]} >= DEPTH_W;
      req_err      = !legal_f3 || misaligned || out_of_range;
   end

   always_comb begin
      case (req_addr[1:0])
         2'd0:    byte_lane = mem_rdata[7:0];
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (req_funct3)
         3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
         3'b100:  load_ext = {24'd0, byte_lane};
         3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
         3'b101:  load_ext = {16'd0, half_lane};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      merged_word = old_q;
      if (half_q) begin
         if (addr_q[1]) merged_word[31:16] = wdata_q;
         else           merged_word[15:0]  = wdata_q;
      end else begin
         case (addr_q[1:0])
            2'd0:    merged_word[7:0]   = wdata_q[7:0];
            2'd1:    merged_word[15:8]  = wdata_q[7:0];
            2'd2:    merged_word[23:16] = wdata_q[7:0];
            default: merged_word[31:24] = wdata_q[7:0];
         endcase
      end
   end

   // stall=1 tells upstream to hold the SB/SH request; the held copy is consumed
   // when MERGE completes and is never re-executed.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      half_d       = half_q;
      wdata_d      = wdata_q;
      old_d        = old_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      access_err_d = 1'b0;
      stall        = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = req_addr;
      mem_wdata    = req_wdata;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  access_err_d = 1'b1;
               end else if (!req_we) begin
                  load_valid_d = 1'b1;
                  load_data_d  = load_ext;
               end else if (req_funct3 == 3'b010) begin
                  mem_we = 1'b1;
               end else begin
                  stall   = 1'b1;
                  addr_d  = req_addr;
                  half_d  = req_funct3[0];
                  wdata_d = req_wdata[15:0];
                  old_d   = mem_rdata;
                  state_d = MERGE;
               end
            end
         end
         MERGE: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = merged_word;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         mem_we = 1'b0;
         stall  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         half_q       <= 1'b0;
         wdata_q      <= '0;
         old_q        <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         access_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         half_q       <= half_d;
         wdata_q      <= wdata_d;
         old_q        <= old_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         access_err_q <= access_err_d;
      end
   end

   assign load_data   = load_data_q;
   assign load_valid  = load_valid_q;
   assign access_err  = access_err_q;
   assign dbg_state_o = (state_q == MERGE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single ops plus hand-written
// back-to-back and reset-during-MERGE sequences, against a falling-edge memory model.
module tb_load_store_unit;

   logic        clk, rst;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, load_valid, access_err, mem_we, dbg_state;
   logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:255];
   int n_tests = 0;
   int n_fail  = 0;

   load_store_unit #(.DEPTH_WORDS(256)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .access_err(access_err), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read sampled on the falling edge, write on the rising edge.
   always @(negedge clk)
      mem_rdata <= (mem_addr[31:2] < 30'd256) ? mem[mem_addr[9:2]] : 32'h0;
   always @(posedge clk)
      if (mem_we && (mem_addr[31:2] < 30'd256)) mem[mem_addr[9:2]] <= mem_wdata;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
   endtask

   typedef struct {
      string       name;
      logic        pre;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_stall;
      int          exp_we;
      logic [31:0] exp_wdata;
      logic        exp_lv;
      logic        exp_err;
      logic [31:0] exp_ld;
      logic [31:0] exp_word;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int stalls = 0;
      int wes = 0;
      int cyc = 0;
      logic done = 1'b0;
      logic [31:0] we_data = '0;
      if (v.pre) mem[32] = 32'hDEADBEEF;
      @(posedge clk); #1;
      drive(1'b1, v.we, v.f3, v.addr, v.wdata);
      while (!done && cyc < 4) begin
         @(negedge clk);
         if (stall) stalls++;
         if (mem_we) begin
            wes++;
            we_data = mem_wdata;
         end
         done = !stall;
         @(posedge clk);
         cyc++;
      end
      #1;
      req_valid = 1'b0;
      chk({v.name, "/done"}, 32'(done), 32'd1);
      chk({v.name, "/stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
      chk({v.name, "/we_pulses"}, 32'(wes), 32'(v.exp_we));
      if (v.exp_we > 0) chk({v.name, "/mem_wdata"}, we_data, v.exp_wdata);
      chk({v.name, "/load_valid"}, 32'(load_valid), 32'(v.exp_lv));
      chk({v.name, "/access_err"}, 32'(access_err), 32'(v.exp_err));
      chk({v.name, "/load_data"}, load_data, v.exp_ld);
      chk({v.name, "/word32"}, mem[32], v.exp_word);
      @(posedge clk); #1;
      chk({v.name, "/pulse_end"}, {30'd0, load_valid, access_err}, 32'd0);
   endtask

   vec_t vecs[18];

   initial begin
      vecs[0]  = '{"lb_83",   1, 0, 3'b000, 32'h83,  32'h0,        0, 0, 32'h0,        1, 0, 32'hFFFFFFDE, 32'hDEADBEEF};
      vecs[1]  = '{"lbu_81",  0, 0, 3'b100, 32'h81,  32'h0,        0, 0, 32'h0,        1, 0, 32'h000000BE, 32'hDEADBEEF};
      vecs[2]  = '{"lh_82",   0, 0, 3'b001, 32'h82,  32'h0,        0, 0, 32'h0,        1, 0, 32'hFFFFDEAD, 32'hDEADBEEF};
      vecs[3]  = '{"lhu_80",  0, 0, 3'b101, 32'h80,  32'h0,        0, 0, 32'h0,        1, 0, 32'h0000BEEF, 32'hDEADBEEF};
      vecs[4]  = '{"sb_81",   1, 1, 3'b000, 32'h81,  32'h00000012, 1, 1, 32'hDEAD12EF, 0, 0, 32'h0000BEEF, 32'hDEAD12EF};
      vecs[5]  = '{"lw_80a",  0, 0, 3'b010, 32'h80,  32'h0,        0, 0, 32'h0,        1, 0, 32'hDEAD12EF, 32'hDEAD12EF};
      vecs[6]  = '{"sh_82",   1, 1, 3'b001, 32'h82,  32'h0000CAFE, 1, 1, 32'hCAFEBEEF, 0, 0, 32'hDEAD12EF, 32'hCAFEBEEF};
      vecs[7]  = '{"sw_80",   0, 1, 3'b010, 32'h80,  32'h01234567, 0, 1, 32'h01234567, 0, 0, 32'hDEAD12EF, 32'h01234567};
      vecs[8]  = '{"lw_80b",  0, 0, 3'b010, 32'h80,  32'h0,        0, 0, 32'h0,        1, 0, 32'h01234567, 32'h01234567};
      vecs[9]  = '{"sh_81e",  1, 1, 3'b001, 32'h81,  32'h0000FFFF, 0, 0, 32'h0,        0, 1, 32'h01234567, 32'hDEADBEEF};
      vecs[10] = '{"lw_82e",  1, 0, 3'b010, 32'h82,  32'h0,        0, 0, 32'h0,        0, 1, 32'h01234567, 32'hDEADBEEF};
      vecs[11] = '{"lw_400e", 1, 0, 3'b010, 32'h400, 32'h0,        0, 0, 32'h0,        0, 1, 32'h01234567, 32'hDEADBEEF};
      vecs[12] = '{"ld_f3_3", 1, 0, 3'b011, 32'h80,  32'h0,        0, 0, 32'h0,        0, 1, 32'h01234567, 32'hDEADBEEF};
      vecs[13] = '{"st_f3_4", 1, 1, 3'b100, 32'h80,  32'hFFFFFFFF, 0, 0, 32'h0,        0, 1, 32'h01234567, 32'hDEADBEEF};
      vecs[14] = '{"lw_3fc",  0, 0, 3'b010, 32'h3FC, 32'h0,        0, 0, 32'h0,        1, 0, 32'h55AA00FF, 32'hDEADBEEF};
      vecs[15] = '{"sb_83",   1, 1, 3'b000, 32'h83,  32'hFFFFFF77, 1, 1, 32'h77ADBEEF, 0, 0, 32'h55AA00FF, 32'h77ADBEEF};
      vecs[16] = '{"lb_80",   0, 0, 3'b000, 32'h80,  32'h0,        0, 0, 32'h0,        1, 0, 32'hFFFFFFEF, 32'h77ADBEEF};
      vecs[17] = '{"lh_80",   0, 0, 3'b001, 32'h80,  32'h0,        0, 0, 32'h0,        1, 0, 32'hFFFFBEEF, 32'h77ADBEEF};

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[32]  = 32'hDEADBEEF;
      mem[255] = 32'h55AA00FF;

      // Reset block: an SW presented during reset must not write or stall.
      rst = 1'b1;
      drive(1'b1, 1'b1, 3'b010, 32'h80, 32'h11111111);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst/mem_we", 32'(mem_we), 32'd0);
      chk("rst/stall", 32'(stall), 32'd0);
      chk("rst/load_data", load_data, 32'd0);
      chk("rst/flags", {30'd0, load_valid, access_err}, 32'd0);
      chk("rst/state", 32'(dbg_state), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = 1'b0;
      chk("rst/word32", mem[32], 32'hDEADBEEF);

      for (int i = 0; i < 18; i++) run_vec(vecs[i]);

      // Back-to-back: LW accepted in the cycle right after MERGE sees the merged word.
      mem[32] = 32'hDEADBEEF;
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 3'b000, 32'h80, 32'h00000042);
      @(posedge clk); #1;
      chk("b2b/merge_state", 32'(dbg_state), 32'd1);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
      @(negedge clk);
      chk("b2b/lw_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b/load_valid", 32'(load_valid), 32'd1);
      chk("b2b/load_data", load_data, 32'hDEADBE42);

      // Reset during MERGE aborts the write.
      mem[32] = 32'hDEADBEEF;
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 3'b000, 32'h80, 32'h00000099);
      @(negedge clk);
      chk("rstm/stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstm/state_merge", 32'(dbg_state), 32'd1);
      chk("rstm/mem_we", 32'(mem_we), 32'd0);
      chk("rstm/stall_low", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = 1'b0;
      chk("rstm/state_idle", 32'(dbg_state), 32'd0);
      chk("rstm/load_data", load_data, 32'd0);
      chk("rstm/flags", {30'd0, load_valid, access_err}, 32'd0);
      @(negedge clk);
      chk("rstm/mem_we_after", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      chk("rstm/word32", mem[32], 32'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
